// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - Registered immediate generator with 2-entry skid buffer and flush
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state;
    logic [XLEN-1:0]   main_imm;
    logic [TAG_W-1:0]  main_tag;
    logic [XLEN-1:0]   skid_imm;
    logic [TAG_W-1:0]  skid_tag;
    logic [31:0]       raw_imm;
    logic              raw_signed;
    logic [63:0]       wide_imm;
    logic [XLEN-1:0]   new_imm;
    logic              accept;
    logic              pop;
    logic              unused_opcode;

    // The opcode field never contributes to an immediate.
    assign unused_opcode = ^in_inst[6:0];

    // Every format is built as a 32-bit value, then widened once.
    always_comb begin
        raw_imm    = 32'd0;
        raw_signed = 1'b1;
        case (in_type)
            3'b000: raw_imm = {{20{in_inst[31]}}, in_inst[31:20]};
            3'b001: raw_imm = {in_inst[31:12], 12'b0};
            3'b010: raw_imm = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
            3'b011: raw_imm = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
            3'b100: raw_imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            3'b101: begin
                raw_signed = 1'b0;
                raw_imm    = (XLEN == 64) ? {26'd0, in_inst[25:20]} : {27'd0, in_inst[24:20]};
            end
            3'b110: begin
                raw_signed = 1'b0;
                raw_imm    = {27'd0, in_inst[19:15]};
            end
            default: begin
                raw_signed = 1'b0;
                raw_imm    = 32'd0;
            end
        endcase
        wide_imm = {{32{raw_signed & raw_imm[31]}}, raw_imm};
        new_imm  = wide_imm[XLEN-1:0];
    end

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign out_imm   = main_imm;
    assign out_tag   = main_tag;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= EMPTY;
            main_imm <= '0;
            main_tag <= '0;
            skid_imm <= '0;
            skid_tag <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    main_imm <= new_imm;
                    main_tag <= in_tag;
                    state    <= ONE;
                end
                ONE: begin
                    if (accept && pop) begin
                        main_imm <= new_imm;
                        main_tag <= in_tag;
                    end else if (accept) begin
                        skid_imm <= new_imm;
                        skid_tag <= in_tag;
                        state    <= TWO;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: if (pop) begin
                    main_imm <= skid_imm;
                    main_tag <= skid_tag;
                    state    <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - Directed and randomised checks of imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [2:0]  in_type;
    logic [31:0] in_tag;
    logic        out_ready;
    logic        in_ready32, in_ready64;
    logic        out_valid32, out_valid64;
    logic [31:0] out_imm32;
    logic [63:0] out_imm64;
    logic [31:0] out_tag32, out_tag64;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  typ;
        logic [31:0] tag;
    } entry_t;

    entry_t q[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst),
        .in_type(in_type), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_tag(out_tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst),
        .in_type(in_type), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] t, input bit x64);
        logic [63:0] r;
        case (t)
            3'd0: r = {{52{i[31]}}, i[31:20]};
            3'd1: r = {{32{i[31]}}, i[31:12], 12'h000};
            3'd2: r = {{44{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            3'd3: r = {{52{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            3'd4: r = {{52{i[31]}}, i[31:25], i[11:7]};
            3'd5: r = x64 ? {58'd0, i[25:20]} : {59'd0, i[24:20]};
            3'd6: r = {59'd0, i[19:15]};
            default: r = 64'd0;
        endcase
        if (!x64) r = {32'd0, r[31:0]};
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] i, input logic [2:0] t, input logic [31:0] g);
        in_valid = v;
        in_inst  = i;
        in_type  = t;
        in_tag   = g;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc, pp;
        rstn = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'd0, 3'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid32, 0);
        chk("rst_in_ready", in_ready32, 1);
        chk("rst_out_imm", out_imm64, 0);
        chk("rst_out_tag", out_tag32, 0);
        rstn = 1'b1;

        // 1: streaming at XLEN=32 with out_ready high
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF00093, 3'd0, 32'h10);
        @(negedge clk);
        chk("s1_i_valid", out_valid32, 1);
        chk("s1_i_imm", out_imm32, 32'hFFFFFFFF);
        chk("s1_i_imm64", out_imm64, 64'hFFFFFFFFFFFFFFFF);
        drive(1'b1, 32'h12345037, 3'd1, 32'h11);
        @(negedge clk);
        chk("s1_u_imm", out_imm32, 32'h12345000);
        chk("s1_u_tag", out_tag32, 32'h11);
        drive(1'b1, 32'hFFDFF06F, 3'd2, 32'h12);
        @(negedge clk);
        chk("s1_j_imm", out_imm32, 32'hFFFFFFFC);
        chk("s1_j_imm64", out_imm64, 64'hFFFFFFFFFFFFFFFC);
        drive(1'b0, 32'd0, 3'd0, 32'd0);
        @(negedge clk);
        chk("s1_drain", out_valid32, 0);

        // 2: back-pressure fills the skid register
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 3'd0, 32'd1);
        @(negedge clk);
        chk("s2_ready_one", in_ready32, 1);
        chk("s2_tag_one", out_tag32, 1);
        drive(1'b1, 32'h00200093, 3'd0, 32'd2);
        @(negedge clk);
        drive(1'b0, 32'd0, 3'd0, 32'd0);
        chk("s2_ready_two", in_ready32, 0);
        chk("s2_hold_tag", out_tag32, 1);
        chk("s2_hold_imm", out_imm32, 1);
        @(negedge clk);
        chk("s2_still_tag", out_tag32, 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("s2_second_tag", out_tag32, 2);
        chk("s2_second_imm", out_imm32, 2);
        chk("s2_ready_back", in_ready32, 1);
        @(negedge clk);
        chk("s2_empty", out_valid32, 0);

        // 3: flush in TWO with a simultaneous input, then flush in ONE with an accept
        out_ready = 1'b0;
        drive(1'b1, 32'h00300093, 3'd0, 32'd3);
        @(negedge clk);
        drive(1'b1, 32'h00400093, 3'd0, 32'd4);
        @(negedge clk);
        chk("s3_two", in_ready32, 0);
        flush = 1'b1;
        drive(1'b1, 32'h00500093, 3'd0, 32'd5);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'd0, 3'd0, 32'd0);
        chk("s3_flush_valid", out_valid32, 0);
        chk("s3_flush_ready", in_ready32, 1);
        out_ready = 1'b1;
        drive(1'b1, 32'h00600093, 3'd0, 32'd6);
        @(negedge clk);
        chk("s3_one_tag", out_tag32, 6);
        flush = 1'b1;
        drive(1'b1, 32'h00700093, 3'd0, 32'd7);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'd0, 3'd0, 32'd0);
        chk("s3_flush_one", out_valid32, 0);
        @(negedge clk);
        chk("s3_no_ghost", out_valid32, 0);

        // 4: asynchronous reset between edges during a burst
        drive(1'b1, 32'h12345037, 3'd1, 32'd8);
        @(negedge clk);
        drive(1'b1, 32'h80000037, 3'd1, 32'd9);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        drive(1'b0, 32'd0, 3'd0, 32'd0);
        #1;
        chk("s4_async_valid", out_valid32, 0);
        chk("s4_async_imm", out_imm32, 0);
        chk("s4_async_imm64", out_imm64, 0);
        chk("s4_async_ready", in_ready32, 1);
        @(negedge clk);
        rstn = 1'b1;
        drive(1'b1, 32'hFFF00093, 3'd0, 32'd10);
        @(negedge clk);
        chk("s4_after_valid", out_valid32, 1);
        chk("s4_after_imm", out_imm32, 32'hFFFFFFFF);
        chk("s4_after_tag", out_tag32, 10);

        // 5: XLEN=64 specific formats against XLEN=32
        drive(1'b1, 32'h80000037, 3'd1, 32'd11);
        @(negedge clk);
        chk("s5_u64", out_imm64, 64'hFFFFFFFF80000000);
        chk("s5_u32", out_imm32, 32'h80000000);
        drive(1'b1, 32'h03F0D093, 3'd5, 32'd12);
        @(negedge clk);
        chk("s5_shamt64", out_imm64, 64'h3F);
        chk("s5_shamt32", out_imm32, 32'h1F);
        drive(1'b1, 32'h000FD073, 3'd6, 32'd13);
        @(negedge clk);
        chk("s5_zimm64", out_imm64, 64'h1F);
        drive(1'b1, 32'hFE000FA3, 3'd4, 32'd14);
        @(negedge clk);
        chk("s5_store64", out_imm64, 64'hFFFFFFFFFFFFFFFF);
        drive(1'b1, 32'h80000063, 3'd3, 32'd15);
        @(negedge clk);
        chk("s5_branch32", out_imm32, 32'hFFFFF000);
        drive(1'b1, 32'hFFFFFFFF, 3'd7, 32'd16);
        @(negedge clk);
        chk("s5_zero_type", out_imm64, 64'd0);
        drive(1'b0, 32'd0, 3'd0, 32'd0);
        @(negedge clk);
        chk("s5_drain", out_valid32, 0);

        // 6: randomised traffic against a queue model
        for (int c = 0; c < 10000; c++) begin
            chk("rnd_valid32", out_valid32, (q.size() != 0));
            chk("rnd_valid64", out_valid64, (q.size() != 0));
            chk("rnd_ready", in_ready32, (q.size() < 2));
            if (q.size() != 0) begin
                chk("rnd_tag", out_tag32, q[0].tag);
                chk("rnd_imm32", out_imm32, ref_imm(q[0].inst, q[0].typ, 1'b0));
                chk("rnd_imm64", out_imm64, ref_imm(q[0].inst, q[0].typ, 1'b1));
            end
            drive(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)), c);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            acc = in_valid && (q.size() < 2);
            pp  = (q.size() != 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (pp) void'(q.pop_front());
                if (acc) q.push_back('{inst: in_inst, typ: in_type, tag: in_tag});
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
